// File: rtl/output_port_scheduler.sv
// Output-port scheduler. Round-robin wormhole lock of one output across five
// requesters (L,N,E,W,S), with a downstream credit counter and an idle watchdog.
module output_port_scheduler #(
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req,
  input  logic [14:0] flit_id,
  input  logic        credit_in,
  output logic [4:0]  grant,
  output logic        flit_fwd,
  output logic        busy,
  output logic [3:0]  credit_cnt,
  output logic        timeout_err
);
  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;

  state_e      state_q, state_d;
  logic [4:0]  grant_q, grant_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [11:0] wd_q, wd_d;
  logic [3:0]  credit_q, credit_d;
  logic        terr_q, terr_d;

  logic [4:0]  elig;
  logic [2:0]  win, nxt_ptr, pick;
  logic [2:0]  win_fid;
  logic        win_req, fwd, pick_vld;
  int          idx;

  // Owner index is recovered from the registered one-hot grant.
  always_comb begin
    win = 3'd0;
    for (int i = 0; i < 5; i++)
      if (grant_q[i]) win = 3'(i);
  end

  assign win_fid = flit_id[3*int'(win) +: 3];
  assign win_req = req[win];
  assign nxt_ptr = (win == 3'd4) ? 3'd0 : win + 3'd1;
  assign fwd     = (state_q == LOCKED) && win_req && (credit_q != 4'd0);

  always_comb begin
    elig = '0;
    for (int i = 0; i < 5; i++)
      elig[i] = req[i] && (flit_id[3*i +: 3] == HDR);
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = 3'd0;
    idx      = 0;
    for (int k = 0; k < 5; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= 5) idx = idx - 5;
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick     = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    wd_d     = wd_q;
    terr_d   = 1'b0;
    credit_d = credit_q;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_vld) begin
          state_d = LOCKED;
          grant_d = 5'b00001 << pick;
        end
      end
      LOCKED: begin
        if (fwd) begin
          wd_d = '0;
          if (win_fid == TAIL) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = nxt_ptr;
          end
        end else if (!win_req) begin
          // A credit stall (req high, no credits) is not idleness.
          if (wd_q == 12'(TIMEOUT - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = nxt_ptr;
            wd_d    = '0;
            terr_d  = 1'b1;
          end else begin
            wd_d = wd_q + 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fwd && !credit_in)
      credit_d = credit_q - 4'd1;
    else if (!fwd && credit_in && (credit_q != 4'(CREDITS)))
      credit_d = credit_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      wd_q     <= '0;
      terr_q   <= 1'b0;
      credit_q <= 4'(CREDITS);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      wd_q     <= wd_d;
      terr_q   <= terr_d;
      credit_q <= credit_d;
    end
  end

  assign grant       = grant_q;
  assign flit_fwd    = fwd;
  assign busy        = (state_q == LOCKED);
  assign credit_cnt  = credit_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: directed literal checks plus randomized traffic
// compared every cycle against a packet-level owner/credit/idle-count model.
module tb_output_port_scheduler;
  localparam int CREDITS = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] fid;
  logic        cin;
  logic [4:0]  grant;
  logic        flit_fwd, busy, timeout_err;
  logic [3:0]  credit_cnt;

  int checks = 0;
  int errors = 0;

  output_port_scheduler #(.CREDITS(CREDITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(fid), .credit_in(cin),
    .grant(grant), .flit_fwd(flit_fwd), .busy(busy),
    .credit_cnt(credit_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: who owns the port, the round-robin start, credits, consecutive idle cycles.
  int owner = -1;
  int rr    = 0;
  int cred  = CREDITS;
  int idle  = 0;
  bit terr  = 1'b0;

  always @(negedge clk) begin
    bit efwd;
    bit tail;
    int cand;
    efwd = 1'b0;
    if (owner >= 0) efwd = req[owner] && (cred > 0);
    chk("grant", 32'(grant), (owner >= 0) ? (32'd1 << owner) : 32'd0);
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("credit_cnt", 32'(credit_cnt), 32'(cred));
    chk("timeout_err", 32'(timeout_err), 32'(terr));
    chk("flit_fwd", 32'(flit_fwd), 32'(efwd));

    if (!rst) begin
      owner = -1; rr = 0; cred = CREDITS; idle = 0; terr = 1'b0;
    end else begin
      terr = 1'b0;
      tail = efwd && (fid[3*owner +: 3] == 3'b100);
      cred = cred - int'(efwd) + int'(cin);
      if (cred > CREDITS) cred = CREDITS;
      if (owner < 0) begin
        for (int k = 0; k < 5; k++) begin
          cand = (rr + k) % 5;
          if (owner < 0 && req[cand] && fid[3*cand +: 3] == 3'b001) owner = cand;
        end
        idle = 0;
      end else if (tail) begin
        rr = (owner + 1) % 5; owner = -1; idle = 0;
      end else if (efwd) begin
        idle = 0;
      end else if (!req[owner]) begin
        idle++;
        if (idle == TIMEOUT) begin
          terr = 1'b1; rr = (owner + 1) % 5; owner = -1; idle = 0;
        end
      end
    end
  end

  function automatic logic [2:0] rand_fid();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 3'b001;
    if (r < 7) return 3'b010;
    if (r < 9) return 3'b100;
    return 3'b000;
  endfunction

  initial begin
    int pr, cr;
    rst = 1'b0; req = '0; fid = '0; cin = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_credit", 32'(credit_cnt), 32'd4);

    // Single L packet: header, header transfer, tail.
    rst = 1'b1; req = 5'b00001; fid = 15'b001;
    tick();
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'b00001);
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_fwd", 32'(flit_fwd), 32'd1);
    tick();
    @(negedge clk);
    chk("credit_4to3", 32'(credit_cnt), 32'd3);
    fid = 15'b100;
    tick();
    @(negedge clk);
    chk("tail_release", 32'(grant), 32'd0);
    chk("tail_credit", 32'(credit_cnt), 32'd2);

    // Simultaneous credit return and transfer at 2, then saturation.
    fid = 15'b001;
    tick();
    cin = 1'b1;
    @(negedge clk);
    chk("both_fwd", 32'(flit_fwd), 32'd1);
    tick();
    @(negedge clk);
    chk("both_hold2", 32'(credit_cnt), 32'd2);
    req = '0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("credit_sat", 32'(credit_cnt), 32'd4);
    cin = 1'b0;

    // Reset mid-packet with one credit left.
    req = 5'b00001; fid = 15'b010;
    tick(); tick(); tick();
    @(negedge clk);
    chk("credit_down1", 32'(credit_cnt), 32'd1);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_credit", 32'(credit_cnt), 32'd4);
    chk("midrst_terr", 32'(timeout_err), 32'd0);

    // Watchdog: header sent, then requester goes quiet.
    rst = 1'b1; req = 5'b00001; fid = 15'b001;
    tick(); tick();
    req = '0;
    repeat (15) tick();
    @(negedge clk);
    chk("wd_15_terr", 32'(timeout_err), 32'd0);
    chk("wd_15_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("wd_16_terr", 32'(timeout_err), 32'd1);
    chk("wd_16_grant", 32'(grant), 32'd0);
    req = 5'b00011; fid = 15'b001001;
    tick();
    @(negedge clk);
    chk("wd_ptr_adv", 32'(grant), 32'b00010);
    chk("wd_pulse_end", 32'(timeout_err), 32'd0);

    // Randomized traffic, varying request density and credit return rate.
    for (int blk = 0; blk < 20; blk++) begin
      pr = $urandom_range(10, 95);
      cr = $urandom_range(5, 60);
      for (int c = 0; c < 150; c++) begin
        rst = ($urandom_range(0, 199) != 0);
        for (int i = 0; i < 5; i++) begin
          req[i] = ($urandom_range(0, 99) < pr);
          fid[3*i +: 3] = rand_fid();
        end
        cin = ($urandom_range(0, 99) < cr);
        tick();
      end
    end

    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
